// File: rtl/can_rx_bit_destuff.sv
// Receive-path CAN/CAN FD bit de-stuffer: flags dynamic and fixed stuff bits, detects stuff errors.
// Define CAN_RX_FD_FIXED_STUFF_EN to build fixed stuffing and the FD stuff-count outputs.
module can_rx_bit_destuff (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sample_point_i,
   input  logic       sampled_bit_i,
   input  logic       stuff_en_i,
   input  logic       fixed_stuff_i,
   input  logic       clear_i,
   output logic       bit_de_stuff_o,
   output logic       stuff_err_o,
   output logic [2:0] stuff_cnt_o,
   output logic [2:0] stuff_cnt_gray_o,
   output logic       stuff_parity_o
);

`ifdef CAN_RX_FD_FIXED_STUFF_EN
   localparam logic FD_EN = 1'b1;
`else
   localparam logic FD_EN = 1'b0;
`endif

   function automatic logic [2:0] bin2gray(input logic [2:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   logic       fixed_act;
   logic       stuff_now;
   logic       same_bit;
   logic       last_bit;
   logic       fixed_q;
   logic       destuff_q;
   logic       err_q;
   logic [2:0] run_cnt;
   logic [2:0] fixed_cnt;
   logic [2:0] stuff_cnt;

   assign fixed_act = FD_EN & fixed_stuff_i;
   // First bit of a fixed-stuff region is flagged before any register can react.
   assign stuff_now = destuff_q | (fixed_act & ~fixed_q);
   assign same_bit  = (sampled_bit_i == last_bit);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_bit  <= 1'b1;
         run_cnt   <= 3'd0;
         fixed_cnt <= 3'd0;
         fixed_q   <= 1'b0;
         destuff_q <= 1'b0;
         err_q     <= 1'b0;
         stuff_cnt <= 3'd0;
      end else if (clear_i) begin
         last_bit  <= 1'b1;
         run_cnt   <= 3'd0;
         fixed_cnt <= 3'd0;
         fixed_q   <= 1'b0;
         destuff_q <= 1'b0;
         err_q     <= 1'b0;
         stuff_cnt <= 3'd0;
      end else begin
         err_q <= 1'b0;
         if (!fixed_act) begin
            fixed_q   <= 1'b0;
            fixed_cnt <= 3'd0;
         end
         if (sample_point_i) begin
            last_bit <= sampled_bit_i;
            if (fixed_act) begin
               // Fixed region: stuff bit, then four data bits, repeating.
               fixed_q <= 1'b1;
               if (stuff_now && same_bit)
                  err_q <= 1'b1;
               if (fixed_cnt == 3'd4) begin
                  fixed_cnt <= 3'd0;
                  destuff_q <= 1'b1;
               end else begin
                  fixed_cnt <= fixed_cnt + 3'd1;
                  destuff_q <= 1'b0;
               end
            end else if (!stuff_en_i) begin
               run_cnt   <= 3'd1;
               destuff_q <= 1'b0;
            end else if (destuff_q) begin
               // The stuff bit itself starts the next run.
               if (same_bit)
                  err_q <= 1'b1;
               run_cnt   <= 3'd1;
               destuff_q <= 1'b0;
               if (FD_EN)
                  stuff_cnt <= stuff_cnt + 3'd1;
            end else if (same_bit) begin
               if (run_cnt >= 3'd4) begin
                  run_cnt   <= 3'd5;
                  destuff_q <= 1'b1;
               end else begin
                  run_cnt <= run_cnt + 3'd1;
               end
            end else begin
               run_cnt <= 3'd1;
            end
         end
      end
   end

   assign bit_de_stuff_o   = stuff_now;
   assign stuff_err_o      = err_q;
   assign stuff_cnt_o      = stuff_cnt;
   assign stuff_cnt_gray_o = bin2gray(stuff_cnt);
   assign stuff_parity_o   = ^stuff_cnt_gray_o;

endmodule

// File: tb/tb_can_rx_bit_destuff.sv
// Scoreboard bench for can_rx_bit_destuff; expectations follow CAN_RX_FD_FIXED_STUFF_EN when defined.
module tb_can_rx_bit_destuff;

`ifdef CAN_RX_FD_FIXED_STUFF_EN
   localparam logic FD = 1'b1;
`else
   localparam logic FD = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       sample_point_i;
   logic       sampled_bit_i;
   logic       stuff_en_i;
   logic       fixed_stuff_i;
   logic       clear_i;
   logic       bit_de_stuff_o;
   logic       stuff_err_o;
   logic [2:0] stuff_cnt_o;
   logic [2:0] stuff_cnt_gray_o;
   logic       stuff_parity_o;

   can_rx_bit_destuff dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .sample_point_i   (sample_point_i),
      .sampled_bit_i    (sampled_bit_i),
      .stuff_en_i       (stuff_en_i),
      .fixed_stuff_i    (fixed_stuff_i),
      .clear_i          (clear_i),
      .bit_de_stuff_o   (bit_de_stuff_o),
      .stuff_err_o      (stuff_err_o),
      .stuff_cnt_o      (stuff_cnt_o),
      .stuff_cnt_gray_o (stuff_cnt_gray_o),
      .stuff_parity_o   (stuff_parity_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       flag;
      logic       err;
      logic [2:0] cnt;
      string      name;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   string      cur_test = "reset";
   int         n_chk = 0;
   int         n_pass = 0;
   logic       mon_en = 1'b0;
   logic       sp_seen = 1'b0;
   logic       flag_cap = 1'b0;
   logic [2:0] gray_lut [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
   logic       par_lut  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [2:0] ec(input int n);
      return FD ? 3'(n % 8) : 3'd0;
   endfunction

   // One sample point (two clocks apart) with its expected flag, error pulse and count.
   task automatic sp(input logic b, input logic ef, input logic ee, input int n, input logic clr);
      exp_t e;
      @(negedge clk_i);
      sample_point_i = 1'b1;
      sampled_bit_i  = b;
      clear_i        = clr;
      e.flag = ef;
      e.err  = ee;
      e.cnt  = ec(n);
      e.name = cur_test;
      exp_q.push_back(e);
      @(negedge clk_i);
      sample_point_i = 1'b0;
      clear_i        = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      chk({cur_test, ".clr_cnt"}, 32'(stuff_cnt_o), 32'd0);
   endtask

   always @(posedge clk_i) begin
      sp_seen  <= sample_point_i;
      flag_cap <= bit_de_stuff_o;
   end

   always @(negedge clk_i) begin
      if (mon_en) begin
         if (sp_seen) begin
            if (exp_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk({mon_e.name, ".flag"}, 32'(flag_cap), 32'(mon_e.flag));
               chk({mon_e.name, ".err"},  32'(stuff_err_o), 32'(mon_e.err));
               chk({mon_e.name, ".cnt"},  32'(stuff_cnt_o), 32'(mon_e.cnt));
               chk({mon_e.name, ".gray"}, 32'(stuff_cnt_gray_o), 32'(gray_lut[mon_e.cnt]));
               chk({mon_e.name, ".par"},  32'(stuff_parity_o), 32'(par_lut[mon_e.cnt]));
            end
         end else begin
            chk("err_idle", 32'(stuff_err_o), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_i          = 1'b1;
      sample_point_i = 1'b0;
      sampled_bit_i  = 1'b1;
      stuff_en_i     = 1'b0;
      fixed_stuff_i  = 1'b0;
      clear_i        = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst.flag", 32'(bit_de_stuff_o), 32'd0);
      chk("rst.err",  32'(stuff_err_o), 32'd0);
      chk("rst.cnt",  32'(stuff_cnt_o), 32'd0);
      chk("rst.gray", 32'(stuff_cnt_gray_o), 32'd0);
      chk("rst.par",  32'(stuff_parity_o), 32'd0);
      mon_en = 1'b1;

      cur_test   = "dyn";
      stuff_en_i = 1'b1;
      repeat (5) sp(1'b0, 1'b0, 1'b0, 0, 1'b0);
      sp(1'b1, 1'b1, 1'b0, 1, 1'b0);

      clr_pulse();
      cur_test = "err";
      repeat (5) sp(1'b1, 1'b0, 1'b0, 0, 1'b0);
      sp(1'b1, 1'b1, 1'b1, 1, 1'b0);

      clr_pulse();
      cur_test = "restart";
      repeat (5) sp(1'b0, 1'b0, 1'b0, 0, 1'b0);
      sp(1'b1, 1'b1, 1'b0, 1, 1'b0);
      repeat (4) sp(1'b1, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b1, 1'b0, 2, 1'b0);

      clr_pulse();
      cur_test = "wrap";
      for (int k = 1; k <= 8; k++) begin
         repeat (5) sp(1'b0, 1'b0, 1'b0, k - 1, 1'b0);
         sp(1'b1, 1'b1, 1'b0, k, 1'b0);
      end

      cur_test = "clear";
      repeat (5) sp(1'b0, 1'b0, 1'b0, 0, 1'b0);
      sp(1'b1, 1'b1, 1'b0, 1, 1'b0);
      repeat (5) sp(1'b0, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b1, 1'b0, 0, 1'b1);

      cur_test = "fixed";
      repeat (5) sp(1'b0, 1'b0, 1'b0, 0, 1'b0);
      sp(1'b1, 1'b1, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b0, 1'b0, 1, 1'b0);
      stuff_en_i    = 1'b0;
      fixed_stuff_i = 1'b1;
      sp(1'b1, FD, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b1, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b1, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b1, FD, FD, 1, 1'b0);
      sp(1'b0, 1'b0, 1'b0, 1, 1'b0);
      fixed_stuff_i = 1'b0;
      sp(1'b1, 1'b0, 1'b0, 1, 1'b0);
      fixed_stuff_i = 1'b1;
      sp(1'b0, FD, 1'b0, 1, 1'b0);

      cur_test      = "async_rst";
      fixed_stuff_i = 1'b0;
      stuff_en_i    = 1'b1;
      repeat (5) sp(1'b1, 1'b0, 1'b0, 1, 1'b0);
      sp(1'b0, 1'b1, 1'b0, 2, 1'b0);
      repeat (4) sp(1'b0, 1'b0, 1'b0, 2, 1'b0);
      chk("pre_rst.flag", 32'(bit_de_stuff_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst.flag", 32'(bit_de_stuff_o), 32'd0);
      chk("arst.err",  32'(stuff_err_o), 32'd0);
      chk("arst.cnt",  32'(stuff_cnt_o), 32'd0);
      chk("arst.gray", 32'(stuff_cnt_gray_o), 32'd0);
      chk("arst.par",  32'(stuff_parity_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("sb_left", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/can_rx_bit_destuff.md
# can_rx_bit_destuff

Receive-path bit de-stuffing unit for the CAN/CAN FD receiver. It observes every sampled bus bit and flags stuff bits so the protocol FSM and shift registers discard them. It detects stuff errors. For ISO CAN FD it also handles the fixed stuff bits of the stuff-count/CRC fields and keeps the modulo-8 dynamic stuff-bit count with its Gray code and parity. It sits directly upstream of the receive protocol FSM and drives that FSM's `bit_de_stuff_i` input.

## Interface
Parameters: none.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `sample_point_i` input 1: one-cycle pulse; `sampled_bit_i` is valid in this cycle.
- `sampled_bit_i` input 1: sampled bus level (1 = recessive).
- `stuff_en_i` input 1: dynamic stuffing active (SOF through end of data/DLC, as framed by the FSM).
- `fixed_stuff_i` input 1: fixed-stuffing region (FD stuff-count and CRC fields). It has priority over `stuff_en_i`.
- `clear_i` input 1: synchronous clear to reset values (bus idle, error, frame start).
- `bit_de_stuff_o` output 1: the current or next sample-point bit is a stuff bit.
- `stuff_err_o` output 1: one-cycle stuff-error pulse.
- `stuff_cnt_o` output 3: dynamic stuff bits modulo 8.
- `stuff_cnt_gray_o` output 3: Gray code of `stuff_cnt_o`.
- `stuff_parity_o` output 1: even parity over `stuff_cnt_gray_o` (XOR of its bits).

## Operation
- Internal state:
  - `last_bit`, reset value 1.
  - `run_cnt` [2:0], reset value 0.
  - `fixed_cnt` [2:0], reset value 0.
  - `fixed_q`, reset value 0.
  - the stuff counter.
- All state updates occur only in `sample_point_i` cycles, except `clear_i`.
- **Idle** (`stuff_en_i`=0 and `fixed_stuff_i`=0), at each sample point:
  - `last_bit` ← `sampled_bit_i`; `run_cnt` ← 1.
  - `bit_de_stuff_o` ← 0.
- **Dynamic** (`stuff_en_i`=1, `fixed_stuff_i`=0), at each sample point:
  - If `bit_de_stuff_o`=1 (stuff bit):
    - If `sampled_bit_i`==`last_bit`, pulse `stuff_err_o`.
    - `last_bit` ← `sampled_bit_i`; `run_cnt` ← 1; `bit_de_stuff_o` ← 0; stuff count +1 (wraps 7→0).
  - Else if `sampled_bit_i`==`last_bit`: `run_cnt`+1. When it reaches 5, `bit_de_stuff_o` ← 1 and `run_cnt` holds at 5.
  - Else: `last_bit` ← `sampled_bit_i`; `run_cnt` ← 1.
- **Fixed** (`fixed_stuff_i`=1):
  - The first sample point in the region (`fixed_q`=0) is a fixed stuff bit. On entry `fixed_q` ← 1, and `bit_de_stuff_o` is forced to 1 combinationally in that sample-point cycle.
  - After the first bit, every fifth bit is a stuff bit: `fixed_cnt` cycles 0 (stuff bit), 1, 2, 3, 4, 0, …
  - In every stuff-bit cycle, pulse `stuff_err_o` if `sampled_bit_i`==`last_bit`.
  - `last_bit` tracks every bit. `run_cnt` is ignored. The stuff count is frozen.
  - When `fixed_stuff_i` falls, `fixed_q` ← 0 and `fixed_cnt` ← 0.
- **Gray code** for counts 0..7 is 000, 001, 011, 010, 110, 111, 101, 100.
- **Clear:** `clear_i`=1 resets all state and outputs to reset values. It overrides a coincident sample point.

## Timing
- Reset values:
  - `bit_de_stuff_o`=0, `stuff_err_o`=0.
  - `stuff_cnt_o`=0, `stuff_cnt_gray_o`=000, `stuff_parity_o`=0.
- Dynamic `bit_de_stuff_o`:
  - Registered.
  - Rises the cycle after the sample point of the 5th equal bit.
  - Falls the cycle after the stuff-bit sample point.
  - It is therefore stable and high throughout the stuff-bit sample-point cycle, which is where the FSM reads it.
- Fixed `bit_de_stuff_o`:
  - The first stuff bit is combinational (`fixed_stuff_i` & ~`fixed_q`).
  - Later stuff bits are registered (high while `fixed_cnt`==0).
- `stuff_err_o` is registered: one-cycle pulse in the cycle after the offending sample point.
- `stuff_cnt_o`, `stuff_cnt_gray_o` and `stuff_parity_o` update one cycle after the stuff-bit sample point.
- `stuff_en_i` falling while `bit_de_stuff_o`=1: the flag clears at the next sample point, with no error check.
- `rst_i` mid-frame: immediate asynchronous return to reset values.

## Configuration
- `CAN_RX_FD_FIXED_STUFF_EN` defined: fixed-stuff mode and the stuff-count outputs are implemented as above.
- Not defined:
  - `fixed_stuff_i` is ignored; the block behaves as if it were 0.
  - `stuff_cnt_o`, `stuff_cnt_gray_o` and `stuff_parity_o` are tied to 0.
  - Classic dynamic de-stuffing only.

## Test plan
- **Dynamic stuff bit:** `stuff_en_i`=1, bits 0,0,0,0,0 then 1 → `bit_de_stuff_o`=1 at the 6th sample point, no `stuff_err_o`, `stuff_cnt_o`=1, gray=001, parity=1.
- **Stuff error:** bits 1,1,1,1,1 then 1 → `stuff_err_o` pulses once one cycle after the 6th sample point.
- **Stuff run restart:** 0×5, stuff bit 1, then 1,1,1,1 → the stuff bit counts as the first of the new run, so `bit_de_stuff_o`=1 before the 6th sample point after the stuff bit.
- **Count wrap:** 8 correct stuff bits → `stuff_cnt_o` wraps to 0, gray=000. Check gray and parity at each step (count 4 → 110, parity 0).
- **Fixed stuffing:** raise `fixed_stuff_i` after last bit 0; send 1, then 4 data bits ending in 1, then 1 → the first bit is flagged with no error; the 6th bit is flagged and `stuff_err_o` pulses; the stuff count is unchanged.
- **Clear priority:** `clear_i` asserted coincident with a sample point while `bit_de_stuff_o`=1 → all outputs return to reset values next cycle, no error pulse.
